// File: rtl/clk_div_prog.sv
// Programmable clock divider for the processor clock: run, halt and single-step
// modes, with a shadowed divide value that takes effect only at a half-period boundary.
module clk_div_prog #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(32'd50_000_000)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [1:0]       mode_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] div_i,
    input  logic             load_i,
    output logic             load_ack_o,
    output logic             clk_o,
    output logic             tick_o
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALT      = 2'd1,
        ST_STEP_IDLE = 2'd2,
        ST_STEP_ACT  = 2'd3
    } state_t;

    state_t           state_r, state_next_s, eff_s;
    logic [WIDTH-1:0] cnt_r, cnt_next_s;
    logic [WIDTH-1:0] div_act_r, div_act_next_s;
    logic [WIDTH-1:0] div_sh_r, div_sh_next_s;
    logic             pend_r, pend_next_s;
    logic [1:0]       half_left_r, half_left_next_s;
    logic             clk_r, clk_next_s;
    logic             tick_r, tick_next_s;
    logic             ack_r, ack_next_s;
    logic             sync1_r, sync2_r, step_prev_r;
    logic             step_rise_s, count_en_s, wrap_s, apply_s;

    // Two-flop synchroniser on the push-button plus an edge-detect flop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_r     <= 1'b0;
            sync2_r     <= 1'b0;
            step_prev_r <= 1'b0;
        end else begin
            sync1_r     <= step_i;
            sync2_r     <= sync1_r;
            step_prev_r <= sync2_r;
        end
    end

    assign step_rise_s = sync2_r & ~step_prev_r;

    // Effective state for this cycle: the mode input wins, except an active step runs to completion
    always_comb begin
        eff_s = ST_HALT;
        case (mode_i)
            2'b00:   eff_s = ST_RUN;
            2'b10:   eff_s = (state_r == ST_STEP_ACT) ? ST_STEP_ACT : ST_STEP_IDLE;
            default: eff_s = ST_HALT;
        endcase
    end

    // Next-state, counter, shadow-load and output computation
    always_comb begin
        state_next_s     = eff_s;
        cnt_next_s       = cnt_r;
        clk_next_s       = clk_r;
        tick_next_s      = 1'b0;
        ack_next_s       = 1'b0;
        div_act_next_s   = div_act_r;
        div_sh_next_s    = div_sh_r;
        pend_next_s      = pend_r;
        half_left_next_s = 2'd0;

        count_en_s = (eff_s == ST_RUN) || (eff_s == ST_STEP_ACT);
        wrap_s     = (cnt_r == div_act_r);
        // While frozen, a pending value may go live at once because the counter restarts
        apply_s    = pend_r && (count_en_s ? wrap_s : 1'b1);

        if (count_en_s) begin
            if (wrap_s) begin
                cnt_next_s  = '0;
                clk_next_s  = ~clk_r;
                tick_next_s = ~clk_r;
            end else begin
                cnt_next_s = cnt_r + WIDTH'(1);
            end
        end else begin
            if (pend_r) begin
                cnt_next_s = '0;
            end else begin
                cnt_next_s = cnt_r;
            end
        end

        if (apply_s) begin
            div_act_next_s = div_sh_r;
            pend_next_s    = 1'b0;
            ack_next_s     = 1'b1;
        end else begin
            div_act_next_s = div_act_r;
        end

        // A strobe in the apply cycle is kept for the following wrap
        if (load_i) begin
            div_sh_next_s = div_i;
            pend_next_s   = 1'b1;
        end else begin
            div_sh_next_s = div_sh_r;
        end

        case (eff_s)
            ST_STEP_ACT: begin
                if (wrap_s) begin
                    half_left_next_s = half_left_r - 2'd1;
                    if (half_left_r == 2'd1) begin
                        state_next_s = ST_STEP_IDLE;
                    end else begin
                        state_next_s = ST_STEP_ACT;
                    end
                end else begin
                    half_left_next_s = half_left_r;
                end
            end
            ST_STEP_IDLE: begin
                if (step_rise_s) begin
                    state_next_s     = ST_STEP_ACT;
                    half_left_next_s = 2'd2;
                end else begin
                    state_next_s = ST_STEP_IDLE;
                end
            end
            default: begin
                half_left_next_s = 2'd0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_HALT;
            cnt_r       <= '0;
            div_act_r   <= DEFAULT_DIV;
            div_sh_r    <= DEFAULT_DIV;
            pend_r      <= 1'b0;
            half_left_r <= 2'd0;
            clk_r       <= 1'b1;
            tick_r      <= 1'b0;
            ack_r       <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            div_act_r   <= div_act_next_s;
            div_sh_r    <= div_sh_next_s;
            pend_r      <= pend_next_s;
            half_left_r <= half_left_next_s;
            clk_r       <= clk_next_s;
            tick_r      <= tick_next_s;
            ack_r       <= ack_next_s;
        end
    end

    assign clk_o      = clk_r;
    assign tick_o     = tick_r;
    assign load_ack_o = ack_r;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed scenarios plus random traffic, every cycle
// compared against a half-period/step-budget reference model.
module tb_clk_div_prog;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         step = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] div_in = '0;
    logic         ack, clko, tick;

    int checks = 0;
    int errors = 0;

    // Reference model: level, cycles spent in the current half, active/shadow
    // divide, remaining half-periods of a step, recent raw button samples.
    bit          m_clk, m_tick, m_ack, m_pend;
    int unsigned m_elapsed, m_div, m_sh;
    int          m_halves;
    bit          h1, h2, h3;

    clk_div_prog #(.WIDTH(W), .DEFAULT_DIV(32'd3)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .mode_i     (mode),
        .step_i     (step),
        .div_i      (div_in),
        .load_i     (load),
        .load_ack_o (ack),
        .clk_o      (clko),
        .tick_o     (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_clk = 1'b1; m_tick = 1'b0; m_ack = 1'b0; m_pend = 1'b0;
        m_elapsed = 0; m_div = 3; m_sh = 3; m_halves = 0;
        h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    endtask

    task automatic model_edge(input logic [1:0] md, input bit ld, input int unsigned dv, input bit st);
        bit counting;
        bit rise;
        rise     = h2 && !h3;
        m_tick   = 1'b0;
        m_ack    = 1'b0;
        counting = (md == 2'd0) || (md == 2'd2 && m_halves > 0);
        if (md != 2'd2) m_halves = 0;
        if (counting) begin
            if (m_elapsed == m_div) begin
                m_clk     = !m_clk;
                m_tick    = m_clk;
                m_elapsed = 0;
                if (m_pend) begin m_div = m_sh; m_pend = 1'b0; m_ack = 1'b1; end
                if (md == 2'd2) m_halves--;
            end else begin
                m_elapsed++;
            end
        end else begin
            if (m_pend) begin m_div = m_sh; m_pend = 1'b0; m_ack = 1'b1; m_elapsed = 0; end
            if (md == 2'd2 && rise) m_halves = 2;
        end
        if (ld) begin m_sh = dv; m_pend = 1'b1; end
        h3 = h2; h2 = h1; h1 = st;
    endtask

    task automatic cycle(input string tag);
        logic [1:0]   md;
        bit           ld, st;
        int unsigned  dv;
        md = mode; ld = load; st = step; dv = div_in;
        @(posedge clk);
        model_edge(md, ld, dv, st);
        #1;
        check({tag, "_clk"},  {31'd0, clko}, {31'd0, m_clk});
        check({tag, "_tick"}, {31'd0, tick}, {31'd0, m_tick});
        check({tag, "_ack"},  {31'd0, ack},  {31'd0, m_ack});
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    task automatic strobe_load(input int unsigned v, input string tag);
        div_in = v; load = 1'b1;
        cycle(tag);
        load = 1'b0;
    endtask

    task automatic pulse_step(input string tag);
        step = 1'b1;
        cycle(tag);
        step = 1'b0;
    endtask

    task automatic hit_reset();
        #3 rst_n = 1'b0;
        #1;
        check("arst_clk",  {31'd0, clko}, 32'd1);
        check("arst_tick", {31'd0, tick}, 32'd0);
        check("arst_ack",  {31'd0, ack},  32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        bit hit;
        int ticks;
        model_reset();
        #12;
        check("rst_clk",  {31'd0, clko}, 32'd1);
        check("rst_tick", {31'd0, tick}, 32'd0);
        check("rst_ack",  {31'd0, ack},  32'd0);
        #11 rst_n = 1'b1;

        // Default divide 3: four cycles high, four low, tick every eight
        ticks = 0;
        for (int i = 1; i <= 24; i++) begin
            cycle("run3");
            if (i == 4) check("run3_fall", {31'd0, clko}, 32'd0);
            if (i == 8) check("run3_rise_tick", {31'd0, tick}, 32'd1);
            ticks += int'(tick);
        end
        check("run3_tick_count", ticks, 32'd3);

        // Load 1 mid-half, then a second load exactly in a wrap cycle
        run(1, "ld1");
        strobe_load(1, "ld1");
        run(8, "ld1");
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (m_elapsed == m_div) hit = 1'b1;
            else cycle("ld1_seek");
        end
        check("ld_wrap_found", {31'd0, hit}, 32'd1);
        strobe_load(2, "ld_wrap");
        run(14, "ld2");

        // Divide 0: toggle every cycle
        strobe_load(0, "div0");
        run(12, "div0");

        // Step mode with divide 2, including a step edge during an active step
        strobe_load(2, "step");
        run(8, "step");
        mode = 2'b10;
        run(4, "step_idle");
        pulse_step("step1");
        run(10, "step1");
        pulse_step("step2");
        run(3, "step2");
        pulse_step("step_ign");
        run(12, "step_ign");

        // Halt mid-period, load while halted, resume
        mode = 2'b00;
        run(4, "halt");
        mode = 2'b01;
        run(4, "halt");
        strobe_load(4, "halt_ld");
        run(4, "halt");
        mode = 2'b11;
        run(2, "halt11");
        mode = 2'b00;
        run(16, "resume");

        // Reset while stepping with a load pending
        mode = 2'b10;
        run(2, "rst_step");
        pulse_step("rst_step");
        run(3, "rst_step");
        strobe_load(1, "rst_step");
        hit_reset();
        mode = 2'b00;
        run(20, "post_rst");

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) step = ~step;
            load = ($urandom_range(0, 7) == 0);
            div_in = W'($urandom_range(0, 4));
            cycle("rand");
        end
        load = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
